// File: rtl/sap1_ctrl_seq_pkg.sv
// Shared definitions for the SAP-1 controller-sequencer: opcodes, ring states,
// control-word layout.
package sap1_ctrl_seq_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned T_NUM = 6;
  localparam int unsigned CW_W  = 12;

  localparam logic [OP_W-1:0] OP_LDA = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  // Bit index of each T-state inside the one-hot ring
  localparam int unsigned T1_IDX = 0;
  localparam int unsigned T2_IDX = 1;
  localparam int unsigned T3_IDX = 2;
  localparam int unsigned T4_IDX = 3;
  localparam int unsigned T5_IDX = 4;
  localparam int unsigned T6_IDX = 5;

  // Control-word bit positions, MSB first
  localparam int unsigned CW_CP = 11;
  localparam int unsigned CW_EP = 10;
  localparam int unsigned CW_LM = 9;
  localparam int unsigned CW_CE = 8;
  localparam int unsigned CW_LI = 7;
  localparam int unsigned CW_EI = 6;
  localparam int unsigned CW_LA = 5;
  localparam int unsigned CW_EA = 4;
  localparam int unsigned CW_SU = 3;
  localparam int unsigned CW_EU = 2;
  localparam int unsigned CW_LB = 1;
  localparam int unsigned CW_LO = 0;

  typedef enum logic [T_NUM-1:0] {
    ST_T1 = 6'b000001,
    ST_T2 = 6'b000010,
    ST_T3 = 6'b000100,
    ST_T4 = 6'b001000,
    ST_T5 = 6'b010000,
    ST_T6 = 6'b100000
  } tstate_e;

  typedef struct packed {
    logic cp;
    logic ep;
    logic lm;
    logic ce;
    logic li;
    logic ei;
    logic la;
    logic ea;
    logic su;
    logic eu;
    logic lb;
    logic lo;
  } ctrl_word_t;

endpackage

// File: rtl/sap1_ctrl_seq_if.sv
// Control-word bus between the SAP-1 sequencer (master) and the datapath (slave).
interface sap1_ctrl_seq_if;
  import sap1_ctrl_seq_pkg::*;

  logic [OP_W-1:0]  opcode;
  logic             cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
  logic             hlt;
  logic [T_NUM-1:0] tstate;

  modport master (
    input  opcode,
    output cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt, tstate
  );

  modport slave (
    output opcode,
    input  cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt, tstate
  );
endinterface

// File: rtl/sap1_ctrl_seq_ring_counter.sv
// Six-state one-hot T-state ring, advancing on the falling edge of clk.
module sap1_ctrl_seq_ring_counter
  import sap1_ctrl_seq_pkg::*;
(
  input  logic    clk,
  input  logic    clr,
  input  logic    hold,
  output tstate_e tstate
);

  tstate_e state_q, state_d;

  always_ff @(negedge clk or posedge clr) begin
    if (clr) state_q <= ST_T1;
    else     state_q <= state_d;
  end

  // Rotate one position per edge; any corrupted code recovers to T1
  always_comb begin
    state_d = state_q;
    if (!hold) begin
      case (state_q)
        ST_T1:   state_d = ST_T2;
        ST_T2:   state_d = ST_T3;
        ST_T3:   state_d = ST_T4;
        ST_T4:   state_d = ST_T5;
        ST_T5:   state_d = ST_T6;
        ST_T6:   state_d = ST_T1;
        default: state_d = ST_T1;
      endcase
    end
  end

  assign tstate = state_q;

endmodule

// File: rtl/sap1_ctrl_seq.sv
// SAP-1 controller-sequencer: T-state ring plus opcode decode into the
// datapath control word, with a sticky halt flag.
module sap1_ctrl_seq
  import sap1_ctrl_seq_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  sap1_ctrl_seq_if.master bus
);

  tstate_e    tstate;
  logic       hlt_q;
  ctrl_word_t cw;

  sap1_ctrl_seq_ring_counter u_ring (
    .clk    (clk),
    .clr    (clr),
    .hold   (hlt_q),
    .tstate (tstate)
  );

  // Halt latches as the ring leaves T4 on an HLT, freezing the ring at T5
  always_ff @(negedge clk or posedge clr) begin
    if (clr)                                    hlt_q <= 1'b0;
    else if (tstate == ST_T4 && bus.opcode == OP_HLT) hlt_q <= 1'b1;
  end

  // Control word decode; clr and halt gate everything to zero
  always_comb begin
    cw = '0;
    if (!clr && !hlt_q) begin
      case (tstate)
        ST_T1: begin cw.ep = 1'b1; cw.lm = 1'b1; end
        ST_T2: cw.cp = 1'b1;
        ST_T3: begin cw.ce = 1'b1; cw.li = 1'b1; end
        ST_T4: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB: begin cw.ei = 1'b1; cw.lm = 1'b1; end
            OP_OUT:                 begin cw.ea = 1'b1; cw.lo = 1'b1; end
            default: ;
          endcase
        end
        ST_T5: begin
          case (bus.opcode)
            OP_LDA:         begin cw.ce = 1'b1; cw.la = 1'b1; end
            OP_ADD, OP_SUB: begin cw.ce = 1'b1; cw.lb = 1'b1; end
            default: ;
          endcase
        end
        ST_T6: begin
          case (bus.opcode)
            OP_ADD: begin cw.eu = 1'b1; cw.la = 1'b1; end
            OP_SUB: begin cw.eu = 1'b1; cw.la = 1'b1; cw.su = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.cp     = cw.cp;
  assign bus.ep     = cw.ep;
  assign bus.lm     = cw.lm;
  assign bus.ce     = cw.ce;
  assign bus.li     = cw.li;
  assign bus.ei     = cw.ei;
  assign bus.la     = cw.la;
  assign bus.ea     = cw.ea;
  assign bus.su     = cw.su;
  assign bus.eu     = cw.eu;
  assign bus.lb     = cw.lb;
  assign bus.lo     = cw.lo;
  assign bus.hlt    = hlt_q;
  assign bus.tstate = T_NUM'(tstate);

endmodule
